delay_term_scheduler: RTL and testbench
=======================================

// Module: delay_term_scheduler
// PURPOSE
//  Sequences one NextElementIncrementTermCalculator per focal-point request.
//  - Accepts (r_0, angle) over a valid/ready request port.
//  - Initiates the calculator, collects N_ELEMENTS (K_n+, K_n-) pairs and hands each to the per-element delay units over a valid/ready stream.
//  - Acks the calculator per term and flags a hung CORDIC with a watchdog.
// PARAMETERS
//  DW_INTEGER      18  integer bits of K_n terms
//  DW_FRACTION      6  fraction bits of K_n terms
//  DW_INPUT         8  r_0 width
//  ANGLE_DW         8  angle width
//  N_ELEMENTS      32  terms per request; must equal calculator element count (32)
//  TIMEOUT_CYCLES 256  max cycles waiting on calc_ready before error
// PORTS  (TW = DW_INTEGER+DW_FRACTION+1, IW = $clog2(N_ELEMENTS))
//  clk            in   1         system clock
//  rst            in   1         asynchronous active-low reset
//  req_valid      in   1         focal-point request valid
//  req_ready      out  1         scheduler can accept request
//  req_r_0        in   DW_INPUT  requested r_0
//  req_angle      in   ANGLE_DW  requested angle
//  calc_initiate  out  1         one-cycle start pulse to calculator
//  calc_ack       out  1         one-cycle term-consumed pulse to calculator
//  calc_r_0       out  DW_INPUT  latched r_0, stable while busy
//  calc_angle     out  ANGLE_DW  latched angle, stable while busy
//  calc_ready     in   1         calculator term valid
//  calc_term_pos  in   TW        calculator K_n (A_0(2n+1)-C_0), signed
//  calc_term_neg  in   TW        calculator K_n (A_0(2n+1)+C_0), signed
//  term_valid     out  1         element term valid downstream
//  term_ready     in   1         downstream accepts term
//  term_index     out  IW        element index n of presented term
//  term_pos       out  TW        registered copy of calc_term_pos
//  term_neg       out  TW        registered copy of calc_term_neg
//  busy           out  1         request in progress (state != IDLE)
//  done           out  1         one-cycle pulse after last term accepted
//  error          out  1         sticky watchdog timeout flag
// BEHAVIOUR
//  Reset (rst=0, async):
//  - State IDLE; all outputs 0, except req_ready=1 once rst released.
//  - index, watchdog and latched regs cleared. Reset mid-stream abandons the request; the calculator shares rst.
//  FSM: IDLE -> START -> WAIT_TERM -> PRESENT -> ACK -> {WAIT_TERM | DONE} -> IDLE; WAIT_TERM -> ERROR -> IDLE.
//  - IDLE: req_ready=1. req_valid&req_ready latches r_0/angle, clears index and error -> START.
//  - START: calc_initiate=1 for exactly 1 cycle; watchdog cleared -> WAIT_TERM.
//  - WAIT_TERM: watchdog++ each cycle.
//    - calc_ready=1: register pos/neg into term_pos/neg -> PRESENT.
//    - watchdog==TIMEOUT_CYCLES-1 without calc_ready -> ERROR (ready wins if same cycle).
//  - PRESENT: term_valid=1; term_pos/neg/index held stable until term_ready. term_valid&term_ready -> ACK.
//  - ACK: calc_ack=1 for 1 cycle.
//    - index==N_ELEMENTS-1 -> DONE.
//    - else index++, watchdog cleared -> WAIT_TERM (calculator drops ready while in RUN2, so no double capture).
//  - DONE: done=1 for 1 cycle -> IDLE.
//  - ERROR: error<=1 (sticky until next accepted request) -> IDLE; no ack issued.
//  Handshake and stream rules:
//  - term_valid never drops without term_ready.
//  - req_ready=0 whenever busy.
//  - calc_r_0/calc_angle constant from START through DONE.
//  Arithmetic:
//  - Terms pass through unmodified, signed, TW bits.
//  - index counts 0..N_ELEMENTS-1, never wraps within a request.
//  - Watchdog saturates; width $clog2(TIMEOUT_CYCLES).
//  Throughput: min 3 cycles/term after first (PRESENT, ACK, WAIT_TERM) with term_ready tied 1.
// STRUCTURE
//  - delay_calc_pkg: sched_state_t enum, TW/IW localparams, N_ELEMENTS_DEFAULT=32.
//  - Sub-module: watchdog_counter (clear, enable, expired) instantiated once.
// TESTING  (bench uses behavioural calculator model: ready 10 cycles after initiate, 2 cycles after each ack)
//  1. rst pulled low mid-PRESENT at index 7 -> next cycle all outputs 0, req_ready=1 after release.
//  2. req r_0=100, angle=0, term_ready=1 -> 32 terms, index 0..31 in order, one done pulse, busy drops next cycle.
//  3. term_ready low 5 cycles at index 3 -> term_valid/pos/neg/index stable, no calc_ack until accept.
//  4. req_valid held high during busy -> req_ready=0, second request accepted only after done.
//  5. model never asserts calc_ready, TIMEOUT_CYCLES=16 -> error=1 16 cycles after START, state IDLE; cleared on next accept.
//  6. calc_ready and watchdog expiry same cycle -> term captured, error stays 0.

Source files
------------

// File: rtl/delay_calc_pkg.sv
// Shared types for the focal-point delay term scheduler.
// State encoding plus default term/index widths.
package delay_calc_pkg;

  localparam int N_ELEMENTS_DEFAULT = 32;
  localparam int TW = 18 + 6 + 1;
  localparam int IW = $clog2(N_ELEMENTS_DEFAULT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_TERM,
    S_PRESENT,
    S_ACK,
    S_DONE,
    S_ERROR
  } sched_state_t;

endpackage

// File: rtl/watchdog_counter.sv
// Saturating cycle counter that flags a stalled calculator.
// Expires once LIMIT cycles have been counted since the last clear.
module watchdog_counter #(
  parameter int LIMIT = 256,
  localparam int CW = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/delay_term_scheduler.sv
// Sequences one increment-term calculation per focal-point request
// and streams the resulting K_n pairs to the per-element delay units.
module delay_term_scheduler
  import delay_calc_pkg::*;
#(
  parameter int DW_INTEGER     = 18,
  parameter int DW_FRACTION    = 6,
  parameter int DW_INPUT       = 8,
  parameter int ANGLE_DW       = 8,
  parameter int N_ELEMENTS     = N_ELEMENTS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [DW_INPUT-1:0]                   req_r_0,
  input  logic [ANGLE_DW-1:0]                   req_angle,
  output logic                                  calc_initiate,
  output logic                                  calc_ack,
  output logic [DW_INPUT-1:0]                   calc_r_0,
  output logic [ANGLE_DW-1:0]                   calc_angle,
  input  logic                                  calc_ready,
  input  logic signed [DW_INTEGER+DW_FRACTION:0] calc_term_pos,
  input  logic signed [DW_INTEGER+DW_FRACTION:0] calc_term_neg,
  output logic                                  term_valid,
  input  logic                                  term_ready,
  output logic [$clog2(N_ELEMENTS)-1:0]         term_index,
  output logic signed [DW_INTEGER+DW_FRACTION:0] term_pos,
  output logic signed [DW_INTEGER+DW_FRACTION:0] term_neg,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error
);

  localparam int IDX_W = $clog2(N_ELEMENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMENTS - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] index;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;

  assign wd_clear   = (state == S_IDLE) ||
                      (state == S_START) ||
                      (state == S_ACK);
  assign wd_enable  = (state == S_WAIT_TERM);
  assign term_index = index;

  watchdog_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      index         <= '0;
      req_ready     <= 1'b0;
      calc_initiate <= 1'b0;
      calc_ack      <= 1'b0;
      calc_r_0      <= '0;
      calc_angle    <= '0;
      term_valid    <= 1'b0;
      term_pos      <= '0;
      term_neg      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      calc_initiate <= 1'b0;
      calc_ack      <= 1'b0;
      done          <= 1'b0;
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            calc_r_0      <= req_r_0;
            calc_angle    <= req_angle;
            index         <= '0;
            error         <= 1'b0;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            calc_initiate <= 1'b1;
            state         <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT_TERM;
        end
        S_WAIT_TERM: begin
          // A term arriving on the expiry cycle still wins.
          if (calc_ready) begin
            term_pos   <= calc_term_pos;
            term_neg   <= calc_term_neg;
            term_valid <= 1'b1;
            state      <= S_PRESENT;
          end else if (wd_expired) begin
            error <= 1'b1;
            state <= S_ERROR;
          end
        end
        S_PRESENT: begin
          if (term_ready) begin
            term_valid <= 1'b0;
            calc_ack   <= 1'b1;
            state      <= S_ACK;
          end
        end
        S_ACK: begin
          if (index == LAST_IDX) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            index <= index + 1'b1;
            state <= S_WAIT_TERM;
          end
        end
        S_DONE, S_ERROR: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_term_scheduler.sv
// Directed/randomised bench for delay_term_scheduler with a
// behavioural calculator model and a term scoreboard.
module tb_delay_term_scheduler;

  localparam int N  = 32;
  localparam int TO = 16;
  localparam int TW = 25;
  localparam int IW = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [7:0]           req_r_0 = '0;
  logic [7:0]           req_angle = '0;
  logic                 calc_initiate;
  logic                 calc_ack;
  logic [7:0]           calc_r_0;
  logic [7:0]           calc_angle;
  logic                 calc_ready = 1'b0;
  logic signed [TW-1:0] calc_term_pos = '0;
  logic signed [TW-1:0] calc_term_neg = '0;
  logic                 term_valid;
  logic                 term_ready = 1'b1;
  logic [IW-1:0]        term_index;
  logic signed [TW-1:0] term_pos;
  logic signed [TW-1:0] term_neg;
  logic                 busy;
  logic                 done;
  logic                 error;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  delay_term_scheduler #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_r_0      (req_r_0),
    .req_angle    (req_angle),
    .calc_initiate(calc_initiate),
    .calc_ack     (calc_ack),
    .calc_r_0     (calc_r_0),
    .calc_angle   (calc_angle),
    .calc_ready   (calc_ready),
    .calc_term_pos(calc_term_pos),
    .calc_term_neg(calc_term_neg),
    .term_valid   (term_valid),
    .term_ready   (term_ready),
    .term_index   (term_index),
    .term_pos     (term_pos),
    .term_neg     (term_neg),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // Calculator model: term ready mdl_init_delay cycles after initiate
  // (0 = never), mdl_ack_delay cycles after each ack; holds until ack.
  int            mdl_init_delay = 10;
  int            mdl_ack_delay  = 2;
  int            m_cnt = 0;
  logic [TW-1:0] q_pos[$];
  logic [TW-1:0] q_neg[$];

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      calc_ready = 1'b0;
      m_cnt      = 0;
      q_pos.delete();
      q_neg.delete();
    end else begin
      if (calc_initiate) begin
        calc_ready = 1'b0;
        m_cnt      = mdl_init_delay;
        q_pos.delete();
        q_neg.delete();
      end else if (calc_ack) begin
        calc_ready = 1'b0;
        m_cnt      = mdl_ack_delay;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          calc_term_pos = TW'($urandom);
          calc_term_neg = TW'($urandom);
          calc_ready    = 1'b1;
          q_pos.push_back(calc_term_pos);
          q_neg.push_back(calc_term_neg);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctrl"}, {req_ready, calc_initiate, calc_ack, term_valid,
                           busy, done, error, term_index}, '0);
    check({tag, "_d0"}, {term_pos, calc_r_0}, '0);
    check({tag, "_d1"}, {term_neg, calc_angle}, '0);
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [7:0] r0, input logic [7:0] ang,
                       input bit hold);
    int c = 0;
    req_r_0   = r0;
    req_angle = ang;
    req_valid = 1'b1;
    while (!req_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("req_accept", {63'd0, req_ready}, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      req_r_0   = ~r0;
      req_angle = ~ang;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic run_request(input logic [7:0] r0, input logic [7:0] ang,
                             input int stall_idx, input int stall_len,
                             input bit rand_rdy, input bit hold);
    int            cyc = 0, exp_idx = 0, dones = 0, inits = 0;
    int            stall_left = stall_len;
    bit            finished = 0, acc_prev = 0;
    bit            prev_vld = 0, prev_rdy = 1;
    logic [TW-1:0] h_pos = '0, h_neg = '0;
    logic [IW-1:0] h_ix = '0;
    issue(r0, ang, hold);
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("error_cleared", {63'd0, error}, 0);
      check("busy", {63'd0, busy}, 1);
      check("req_ready_busy", {63'd0, req_ready}, 0);
      check("calc_r_0", {56'd0, calc_r_0}, {56'd0, r0});
      check("calc_angle", {56'd0, calc_angle}, {56'd0, ang});
      check("calc_ack", {63'd0, calc_ack}, {63'd0, acc_prev});
      if (prev_vld && !prev_rdy)
        check("valid_hold", {63'd0, term_valid}, 1);
      if (calc_initiate) inits++;
      if (done) begin
        dones++;
        finished = 1;
      end
      term_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (term_valid && exp_idx == stall_idx && stall_left > 0) begin
        if (stall_left == stall_len) begin
          h_pos = term_pos;
          h_neg = term_neg;
          h_ix  = term_index;
        end else begin
          check("stall_pos", {39'd0, term_pos}, {39'd0, h_pos});
          check("stall_neg", {39'd0, term_neg}, {39'd0, h_neg});
          check("stall_idx", {59'd0, term_index}, {59'd0, h_ix});
        end
        stall_left--;
        term_ready = 1'b0;
      end
      prev_vld = term_valid;
      prev_rdy = term_ready;
      acc_prev = term_valid && term_ready;
      if (acc_prev) begin
        check("term_index", {59'd0, term_index}, 64'(exp_idx));
        if (q_pos.size() == 0) begin
          check("term_unexpected", 1, 0);
        end else begin
          check("term_pos", {39'd0, term_pos}, {39'd0, q_pos[0]});
          check("term_neg", {39'd0, term_neg}, {39'd0, q_neg[0]});
          void'(q_pos.pop_front());
          void'(q_neg.pop_front());
        end
        exp_idx++;
      end
    end
    check("stream_finished", {63'd0, finished}, 1);
    check("done_pulses", 64'(dones), 1);
    check("initiate_pulses", 64'(inits), 1);
    check("term_count", 64'(exp_idx), N);
    check("error_after_stream", {63'd0, error}, 0);
    term_ready = 1'b1;
    @(negedge clk);
    check("busy_drop", {63'd0, busy}, 0);
    check("req_ready_idle", {63'd0, req_ready}, 1);
    check("done_one_cycle", {63'd0, done}, 0);
  endtask

  task automatic run_timeout(input logic [7:0] r0, input logic [7:0] ang);
    int err_cyc = -1;
    bit leaked = 0;
    issue(r0, ang, 0);
    for (int c = 1; c <= 60 && err_cyc < 0; c++) begin
      @(negedge clk);
      if (term_valid || calc_ack) leaked = 1;
      if (error) err_cyc = c;
    end
    // START cycle, TO waiting cycles, then the flag registers.
    check("timeout_cycle", 64'(err_cyc), 64'(TO + 2));
    check("timeout_no_term", {63'd0, leaked}, 0);
    @(negedge clk);
    check("timeout_idle", {62'd0, busy, req_ready}, 64'b01);
    check("timeout_sticky", {63'd0, error}, 1);
  endtask

  task automatic run_reset(input logic [7:0] r0, input logic [7:0] ang);
    bit found = 0;
    issue(r0, ang, 0);
    term_ready = 1'b1;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (term_valid && term_index == IW'(7)) found = 1;
    end
    check("reached_index7", {63'd0, found}, 1);
    term_ready = 1'b0;
    rst        = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    check_idle_zero("midrst_hold");
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_rdy", {62'd0, req_ready, busy}, 64'b10);
    term_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] r, a;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", {63'd0, req_ready}, 1);

    run_request(8'd100, 8'd0, -1, 0, 0, 0);
    run_request(8'($urandom), 8'($urandom), 3, 5, 0, 0);

    r = 8'($urandom);
    a = 8'($urandom);
    run_request(r, a, -1, 0, 0, 1);
    run_request(~r, ~a, -1, 0, 0, 0);

    repeat (3) run_request(8'($urandom), 8'($urandom), -1, 0, 1, 0);

    mdl_init_delay = 0;
    run_timeout(8'($urandom), 8'($urandom));
    mdl_init_delay = TO + 1;
    run_timeout(8'($urandom), 8'($urandom));
    mdl_init_delay = TO;
    run_request(8'($urandom), 8'($urandom), -1, 0, 0, 0);
    mdl_init_delay = 10;

    run_reset(8'($urandom), 8'($urandom));
    run_request(8'($urandom), 8'($urandom), 5, 3, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
